csa_sum_pipe: RTL and testbench
===============================

Name: csa_sum_pipe

Overview:
- Parametrised N-operand unsigned adder. A chain of 3:2 carry-save stages feeds a final carry-propagate stage.
- Successor to the fixed 4×6-bit carry-save pipeline. Operand width and count are generalised, a valid/ready handshake with full back-pressure is added, and output width can be narrowed.
- Sits between operand producers (filter taps, partial products) and downstream accumulators.

Parameters:
- W, 6, operand width in bits (2..32).
- N, 4, number of operands (3..8).
- FULL_W, W+$clog2(N), internal carry-save and CPA width. Cannot overflow. Derived only, not for override.
- OUT_W, FULL_W, result width (1..FULL_W). Smaller values truncate or saturate (see Optional Feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand vector valid.
- in_ready  out  1  block can accept this cycle.
- in_data  in  N*W  packed operands; operand k = in_data[k*W +: W], unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  OUT_W  result.
- ovf  out  1  true sum exceeded 2^OUT_W-1; qualified by out_valid.

Behaviour:
- Reset: rst=1 asynchronously clears every stage valid bit and every data register. Outputs: out_valid=0, sum=0, ovf=0.
- Reset mid-operation: all in-flight vectors are discarded. Nothing is emitted after rst deasserts until new inputs are accepted.
- Advance rule:
  - adv = !out_valid | out_ready.
  - in_ready = adv (combinational).
  - When adv=1, every stage loads from its predecessor in the same edge.
  - When adv=0, all stages hold, including bubbles. This is a global stall with no bubble collapsing.
- Accept: a transfer occurs when in_valid & in_ready. On a transfer, stage 0 registers all N operands and sets v0=1. If adv=1 and in_valid=0, v0 loads 0 (a bubble).
- Stages, each with its own valid bit:
  - S0: input register holding all N operands.
  - S1: 3:2 compress operands 0,1,2 into (s,c). c is shifted left by 1 with bit 0 = 0. Both are FULL_W wide.
  - Sk for k = 2..N-2: 3:2 compress (s, c, operand k+1) into new (s,c). Unused operands travel alongside unchanged.
  - S(N-1): CPA computes full = s + c at FULL_W and forms sum/ovf.
- Timing:
  - Latency: a vector accepted at edge t appears with out_valid=1 after edge t+N-1 when there are no stalls. For N=4 that is 4 register stages.
  - Throughput: 1 vector per cycle while out_ready=1.
- Ordering: results leave strictly in acceptance order. No vector is dropped or duplicated under any out_ready pattern.
- Output hold: while out_valid & !out_ready, sum and ovf are held stable.
- Width rule: ovf = (full >> OUT_W) != 0. When OUT_W == FULL_W, ovf is always 0.
- Simultaneous events: in_valid & out_valid & out_ready in the same cycle means accept and emit together, with pipeline occupancy unchanged.

Optional Feature:
- Macro: CSA_PIPE_SAT_EN.
- Defined: when ovf=1, sum = 2^OUT_W-1 (all ones). Otherwise sum = full.
- Undefined: sum = full[OUT_W-1:0] (modulo wrap). ovf is still reported.
- With OUT_W == FULL_W, the two builds are identical.

Test Plan:
- Defaults (W=6, N=4), out_ready=1. Accept {63,63,63,63} at edge 0, then {1,2,3,4}. Expect out_valid with sum=252, ovf=0 after edge 3, then sum=10 on the next cycle. No gaps.
- Back-pressure: stream 8 random vectors while out_ready toggles 1,0,0,1,0,1... Every result must equal the scoreboard sum, in order. in_ready must be 0 exactly when out_valid=1 and out_ready=0. sum must be stable during stalls.
- Bubbles: in_valid pattern 1,0,1,0,0,1 with out_ready=1. The out_valid pattern must be the same sequence delayed by N-1 cycles.
- Reset mid-operation: accept 3 vectors, assert rst asynchronously between edges for 1 cycle. out_valid must drop to 0 immediately and nothing appears for those vectors. A new vector {5,6,7,8} must yield 26 after 4 cycles.
- Width/ovf, OUT_W=7: input {63,63,63,63}.
  - Without CSA_PIPE_SAT_EN: sum=124, ovf=1.
  - With it: sum=127, ovf=1.
  - Input {10,20,30,40} gives sum=100, ovf=0 in both builds.
- Parameter sweep: N=3,W=8 with {255,255,255} gives 765 after 3 cycles. N=8,W=4 with all operands 15 gives 120 after 8 cycles.

Source files
------------

// File: rtl/csa_sum_pipe.sv
// ---------------------------------------------------------------------------
// csa_sum_pipe
//   Parametrised N-operand unsigned adder. Stage 0 registers the operand
//   vector. Stages 1..N-2 are 3:2 carry-save compressors that fold in one
//   operand each. Stage N-1 is the carry-propagate adder that forms sum/ovf.
//   Every stage has its own valid bit. A single advance signal moves the whole
//   pipe at once. When the output is blocked, every stage holds, including
//   bubbles.
//
//   Optional build macro: CSA_PIPE_SAT_EN
//     defined   -> sum saturates to all ones when the true sum overflows OUT_W
//     undefined -> sum wraps modulo 2^OUT_W
//     ovf is reported in both builds.
//
// Parameters:
//   W      operand width (2..32)
//   N      number of operands (3..8)
//   OUT_W  result width (1..W+$clog2(N))
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; clears valids and data
//   in_valid   operand vector valid
//   in_ready   block can accept this cycle (= !out_valid | out_ready)
//   in_data    packed operands, operand k = in_data[k*W +: W]
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sum        result (OUT_W bits)
//   ovf        true sum exceeded 2^OUT_W-1, qualified by out_valid
// ---------------------------------------------------------------------------
module csa_sum_pipe #(
    parameter int W     = 6,
    parameter int N     = 4,
    parameter int OUT_W = W + $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*W-1:0]     in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   sum,
    output logic               ovf
);

    // Wide enough for the sum of N W-bit operands, so the carry-save chain
    // never loses a carry.
    localparam int FULL_W = W + $clog2(N);

    // 3:2 compressor returning {s, c}. The carry word is shifted left by one.
    // The dropped top carry bit is provably zero because FULL_W cannot overflow.
    function automatic logic [2*FULL_W-1:0] csa32(
        input logic [FULL_W-1:0] a,
        input logic [FULL_W-1:0] b,
        input logic [FULL_W-1:0] x
    );
        logic [FULL_W-1:0] s_v;
        logic [FULL_W-1:0] maj_v;
        s_v   = a ^ b ^ x;
        maj_v = (a & b) | (a & x) | (b & x);
        return {s_v, maj_v << 1'b1};
    endfunction

    // Zero-extend one operand to the internal width.
    function automatic logic [FULL_W-1:0] ext(input logic [W-1:0] op);
        return {{(FULL_W-W){1'b0}}, op};
    endfunction

    logic                adv_s;
    logic [N-1:0]        v_r;
    // Operand carriers: ops_r[0] is the input register. Later entries carry
    // the not-yet-consumed operands alongside the carry-save words.
    logic [N*W-1:0]      ops_r  [0:N-3];
    logic [FULL_W-1:0]   s_r    [1:N-2];
    logic [FULL_W-1:0]   c_r    [1:N-2];
    logic [FULL_W-1:0]   s_src  [0:N-3];
    logic [FULL_W-1:0]   c_src  [0:N-3];
    logic [FULL_W-1:0]   s_nxt  [1:N-2];
    logic [FULL_W-1:0]   c_nxt  [1:N-2];
    logic [FULL_W-1:0]   full_s;
    logic [OUT_W-1:0]    sum_nxt;
    logic                ovf_nxt;
    logic [OUT_W-1:0]    sum_r;
    logic                ovf_r;

    // Global advance: everything moves unless a valid result is blocked.
    assign adv_s     = !v_r[N-1] || out_ready;
    assign in_ready  = adv_s;
    assign out_valid = v_r[N-1];
    assign sum       = sum_r;
    assign ovf       = ovf_r;

    // Carry-save chain: stage k compresses (s, c) of stage k-1 with operand k+1.
    // The first stage treats operands 0 and 1 as its incoming (s, c) pair.
    always_comb begin
        s_src = '{default: {FULL_W{1'b0}}};
        c_src = '{default: {FULL_W{1'b0}}};
        s_nxt = '{default: {FULL_W{1'b0}}};
        c_nxt = '{default: {FULL_W{1'b0}}};
        s_src[0] = ext(ops_r[0][0 +: W]);
        c_src[0] = ext(ops_r[0][W +: W]);
        for (int j = 1; j <= N - 3; j++) begin
            s_src[j] = s_r[j];
            c_src[j] = c_r[j];
        end
        for (int k = 1; k <= N - 2; k++) begin
            {s_nxt[k], c_nxt[k]} = csa32(s_src[k-1], c_src[k-1],
                                         ext(ops_r[k-1][(k+1)*W +: W]));
        end
    end

    assign full_s = s_r[N-2] + c_r[N-2];

    // Output width handling: no overflow is possible at full width.
    if (OUT_W == FULL_W) begin : g_full
        assign ovf_nxt = 1'b0;
        assign sum_nxt = full_s;
    end else begin : g_narrow
        assign ovf_nxt = |full_s[FULL_W-1:OUT_W];
`ifdef CSA_PIPE_SAT_EN
        assign sum_nxt = ovf_nxt ? {OUT_W{1'b1}} : full_s[OUT_W-1:0];
`else
        assign sum_nxt = full_s[OUT_W-1:0];
`endif
    end

    // Pipeline registers: all stages load together on advance, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r   <= {N{1'b0}};
            sum_r <= {OUT_W{1'b0}};
            ovf_r <= 1'b0;
            for (int j = 0; j <= N - 3; j++) begin
                ops_r[j] <= {(N*W){1'b0}};
            end
            for (int k = 1; k <= N - 2; k++) begin
                s_r[k] <= {FULL_W{1'b0}};
                c_r[k] <= {FULL_W{1'b0}};
            end
        end else if (adv_s) begin
            v_r      <= {v_r[N-2:0], in_valid};
            ops_r[0] <= in_data;
            for (int j = 1; j <= N - 3; j++) begin
                ops_r[j] <= ops_r[j-1];
            end
            for (int k = 1; k <= N - 2; k++) begin
                s_r[k] <= s_nxt[k];
                c_r[k] <= c_nxt[k];
            end
            sum_r <= sum_nxt;
            ovf_r <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_csa_sum_pipe.sv
module tb_csa_sum_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Default build: W=6, N=4, OUT_W=8
    logic        iv0, ir0, ov0, or0, ovf0;
    logic [23:0] d0;
    logic [7:0]  s0;
    // W=6, N=4, OUT_W=7
    logic        iv1, ir1, ov1, ovf1;
    logic [23:0] d1;
    logic [6:0]  s1;
    // W=8, N=3
    logic        iv2, ir2, ov2, ovf2;
    logic [23:0] d2;
    logic [9:0]  s2;
    // W=4, N=8
    logic        iv3, ir3, ov3, ovf3;
    logic [31:0] d3;
    logic [6:0]  s3;
    logic        rdy_x;

    csa_sum_pipe u_dut (.clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_data(d0),
                        .out_valid(ov0), .out_ready(or0), .sum(s0), .ovf(ovf0));
    csa_sum_pipe #(.W(6), .N(4), .OUT_W(7)) u_dut7 (.clk(clk), .rst(rst), .in_valid(iv1),
                        .in_ready(ir1), .in_data(d1), .out_valid(ov1), .out_ready(rdy_x),
                        .sum(s1), .ovf(ovf1));
    csa_sum_pipe #(.W(8), .N(3)) u_dut3 (.clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
                        .in_data(d2), .out_valid(ov2), .out_ready(rdy_x), .sum(s2), .ovf(ovf2));
    csa_sum_pipe #(.W(4), .N(8)) u_dut8 (.clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3),
                        .in_data(d3), .out_valid(ov3), .out_ready(rdy_x), .sum(s3), .ovf(ovf3));

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] exp_sum;
        logic        exp_ovf;
    } vec_t;

`ifdef CSA_PIPE_SAT_EN
    localparam logic [15:0] SUM_252_W7 = 16'd127;
    localparam logic [15:0] SUM_128_W7 = 16'd127;
`else
    localparam logic [15:0] SUM_252_W7 = 16'd124;
    localparam logic [15:0] SUM_128_W7 = 16'd0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tv  [7];
        vec_t tv7 [4];
        bit   rp  [16];
        bit   bp  [6];
        logic [7:0] q [$];
        logic [7:0] held;
        logic [7:0] expv;
        logic [5:0] o0, o1, o2, o3;
        logic       hold_chk;
        int sent, got, cyc;

        tv[0] = '{data: {8'd0, 6'd63, 6'd63, 6'd63, 6'd63}, exp_sum: 16'd252, exp_ovf: 1'b0};
        tv[1] = '{data: {8'd0, 6'd4, 6'd3, 6'd2, 6'd1},     exp_sum: 16'd10,  exp_ovf: 1'b0};
        tv[2] = '{data: {8'd0, 6'd0, 6'd0, 6'd0, 6'd0},     exp_sum: 16'd0,   exp_ovf: 1'b0};
        tv[3] = '{data: {8'd0, 6'd0, 6'd0, 6'd0, 6'd63},    exp_sum: 16'd63,  exp_ovf: 1'b0};
        tv[4] = '{data: {8'd0, 6'd63, 6'd0, 6'd0, 6'd0},    exp_sum: 16'd63,  exp_ovf: 1'b0};
        tv[5] = '{data: {8'd0, 6'd1, 6'd8, 6'd16, 6'd32},   exp_sum: 16'd57,  exp_ovf: 1'b0};
        tv[6] = '{data: {8'd0, 6'd0, 6'd63, 6'd63, 6'd0},   exp_sum: 16'd126, exp_ovf: 1'b0};

        tv7[0] = '{data: {8'd0, 6'd63, 6'd63, 6'd63, 6'd63}, exp_sum: SUM_252_W7, exp_ovf: 1'b1};
        tv7[1] = '{data: {8'd0, 6'd40, 6'd30, 6'd20, 6'd10}, exp_sum: 16'd100,    exp_ovf: 1'b0};
        tv7[2] = '{data: {8'd0, 6'd0, 6'd1, 6'd63, 6'd63},   exp_sum: 16'd127,    exp_ovf: 1'b0};
        tv7[3] = '{data: {8'd0, 6'd0, 6'd2, 6'd63, 6'd63},   exp_sum: SUM_128_W7, exp_ovf: 1'b1};

        rp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
               1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0; iv3 = 1'b0;
        d0 = 24'd0; d1 = 24'd0; d2 = 24'd0; d3 = 32'd0;
        or0 = 1'b1; rdy_x = 1'b1;
        #12;
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_out_valid", ov0, 1'b0);
        check("rst_sum", s0, 8'd0);
        check("rst_ovf", ovf0, 1'b0);
        check("rst_in_ready", ir0, 1'b1);
        check("rst_in_ready_w7", ir1, 1'b1);
        check("rst_in_ready_n3", ir2, 1'b1);
        check("rst_in_ready_n8", ir3, 1'b1);

        // Back-to-back table stream, out_ready=1: result c-3 after edge c
        for (int c = 0; c < 10; c++) begin
            if (c < 7) begin
                iv0 = 1'b1;
                d0  = tv[c].data[23:0];
            end else begin
                iv0 = 1'b0;
            end
            step();
            if (c >= 3) begin
                check("tbl_valid", ov0, 1'b1);
                check("tbl_sum", s0, tv[c-3].exp_sum);
                check("tbl_ovf", ovf0, tv[c-3].exp_ovf);
            end else begin
                check("tbl_lat_valid", ov0, 1'b0);
            end
        end
        iv0 = 1'b0;
        step();
        check("tbl_drained", ov0, 1'b0);

        // Back-pressure with a scoreboard
        sent = 0; got = 0; cyc = 0;
        while (got < 8 && cyc < 200) begin
            or0 = rp[cyc % 16];
            if (sent < 8) begin
                o0 = 6'($urandom_range(0, 63));
                o1 = 6'($urandom_range(0, 63));
                o2 = 6'($urandom_range(0, 63));
                o3 = 6'($urandom_range(0, 63));
                d0 = {o3, o2, o1, o0};
                iv0 = 1'b1;
            end else begin
                iv0 = 1'b0;
            end
            #1;
            check("bp_in_ready", ir0, !(ov0 && !or0));
            if (iv0 && ir0) begin
                expv = 8'(o0) + 8'(o1) + 8'(o2) + 8'(o3);
                q.push_back(expv);
                sent++;
            end
            if (ov0 && or0) begin
                if (q.size() == 0) begin
                    check("bp_extra_result", 32'd1, 32'd0);
                end else begin
                    check("bp_sum", s0, q.pop_front());
                end
                got++;
            end
            hold_chk = ov0 && !or0;
            held     = s0;
            step();
            if (hold_chk) begin
                check("bp_hold_valid", ov0, 1'b1);
                check("bp_hold_sum", s0, held);
            end
            cyc++;
        end
        check("bp_count", got, 8);
        iv0 = 1'b0;
        or0 = 1'b1;
        step();

        // Bubbles: out_valid pattern is in_valid pattern delayed by 3 edges
        for (int c = 0; c < 9; c++) begin
            iv0 = (c < 6) ? bp[c] : 1'b0;
            d0  = {18'd0, 6'(c + 1)};
            step();
            if (c >= 3) begin
                check("bubble_valid", ov0, bp[c-3]);
                if (bp[c-3]) begin
                    check("bubble_sum", s0, c - 2);
                end
            end else begin
                check("bubble_valid_early", ov0, 1'b0);
            end
        end

        // Reset mid-operation
        for (int c = 0; c < 4; c++) begin
            iv0 = (c < 3);
            d0  = {6'd9, 6'd9, 6'd9, 6'(c + 1)};
            step();
        end
        iv0 = 1'b0;
        check("mid_pre_valid", ov0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", ov0, 1'b0);
        check("mid_rst_sum", s0, 8'd0);
        check("mid_rst_ovf", ovf0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            check("mid_flush_valid", ov0, 1'b0);
        end
        d0 = {6'd8, 6'd7, 6'd6, 6'd5};
        for (int c = 0; c < 4; c++) begin
            iv0 = (c == 0);
            step();
            check("mid_new_valid", ov0, (c == 3));
            if (c == 3) begin
                check("mid_new_sum", s0, 8'd26);
            end
        end
        iv0 = 1'b0;

        // OUT_W=7 width / overflow behaviour
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                iv1 = 1'b1;
                d1  = tv7[c].data[23:0];
            end else begin
                iv1 = 1'b0;
            end
            step();
            if (c >= 3) begin
                check("w7_valid", ov1, 1'b1);
                check("w7_sum", s1, tv7[c-3].exp_sum);
                check("w7_ovf", ovf1, tv7[c-3].exp_ovf);
            end
        end
        iv1 = 1'b0;

        // N=3, W=8: all ones, result after the third edge
        d2 = {8'd255, 8'd255, 8'd255};
        for (int c = 0; c < 4; c++) begin
            iv2 = (c == 0);
            step();
            check("n3_valid", ov2, (c == 2));
            if (c == 2) begin
                check("n3_sum", s2, 10'd765);
                check("n3_ovf", ovf2, 1'b0);
            end
        end
        iv2 = 1'b0;

        // N=8, W=4: all operands 15, result after the eighth edge
        d3 = 32'hFFFF_FFFF;
        for (int c = 0; c < 9; c++) begin
            iv3 = (c == 0);
            step();
            check("n8_valid", ov3, (c == 7));
            if (c == 7) begin
                check("n8_sum", s3, 7'd120);
                check("n8_ovf", ovf3, 1'b0);
            end
        end
        iv3 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
